// File: rtl/lemming_pkg.sv
// Shared types and default sizing for the lemming dig scheduler.
package lemming_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIG     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int N_LEM_DEF      = 4;
  localparam int DIG_CYCLES_DEF = 8;

endpackage

// File: rtl/lemming_rr_pick.sv
// Round-robin pick: first eligible index at or after rr_ptr, wrapping to 0.
module lemming_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] rr_ptr,
  output logic          valid,
  output logic [IW-1:0] pick
);

  logic [N-1:0] upper_mask;
  logic [N-1:0] upper;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign upper_mask[gi] = (IW'(gi) >= rr_ptr);
    end
  endgenerate

  assign upper = eligible & upper_mask;

  // Lowest set bit of the masked vector wins; otherwise wrap to the full vector.
  always_comb begin
    valid = |eligible;
    pick  = '0;
    if (|upper) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (upper[i]) pick = IW'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (eligible[i]) pick = IW'(i);
      end
    end
  end

endmodule

// File: rtl/lemming_dig_sched.sv
// Round-robin scheduler sharing one digger among N_LEM lemming walkers.
module lemming_dig_sched
  import lemming_pkg::*;
#(
  parameter int N_LEM      = N_LEM_DEF,
  parameter int DIG_CYCLES = DIG_CYCLES_DEF,
  parameter int IW         = $clog2(N_LEM),
  parameter int CW         = $clog2(DIG_CYCLES) + 1
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [N_LEM-1:0] dig_req,
  input  logic [N_LEM-1:0] ground,
  output logic [N_LEM-1:0] dig_gnt,
  output logic [IW-1:0]    dig_owner,
  output logic             dig_active,
  output logic             dig_done,
  output logic             dig_abort
);

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [IW-1:0]    rr_ptr_reg;
  logic [N_LEM-1:0] gnt_reg;
  logic [IW-1:0]    owner_reg;
  logic             done_reg;
  logic             abort_reg;

  logic [N_LEM-1:0] eligible;
  logic             pick_valid;
  logic [IW-1:0]    pick;
  logic [IW-1:0]    ptr_next;

  assign eligible = dig_req & ground;
  assign ptr_next = (owner_reg == IW'(N_LEM - 1)) ? '0 : owner_reg + IW'(1);

  lemming_rr_pick #(
    .N  (N_LEM),
    .IW (IW)
  ) u_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_reg),
    .valid    (pick_valid),
    .pick     (pick)
  );

  always_ff @(posedge clk) begin
    if (areset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      rr_ptr_reg <= '0;
      gnt_reg    <= '0;
      owner_reg  <= '0;
      done_reg   <= 1'b0;
      abort_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            gnt_reg   <= {{(N_LEM - 1){1'b0}}, 1'b1} << pick;
            owner_reg <= pick;
            cnt_reg   <= CW'(DIG_CYCLES - 1);
            state_reg <= DIG;
          end
        end
        DIG: begin
          // Completion is checked first so it wins over a same-cycle fall.
          if (cnt_reg == '0) begin
            gnt_reg    <= '0;
            done_reg   <= 1'b1;
            rr_ptr_reg <= ptr_next;
            state_reg  <= RELEASE;
          end else if (!ground[owner_reg]) begin
            gnt_reg    <= '0;
            abort_reg  <= 1'b1;
            rr_ptr_reg <= ptr_next;
            state_reg  <= RELEASE;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        RELEASE: begin
          done_reg  <= 1'b0;
          abort_reg <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!areset) begin
      assert ($onehot0(gnt_reg));
      assert (!(done_reg && abort_reg));
      assert (!(state_reg == RELEASE && gnt_reg != '0));
    end
  end

  assign dig_gnt    = gnt_reg;
  assign dig_owner  = owner_reg;
  assign dig_active = |gnt_reg;
  assign dig_done   = done_reg;
  assign dig_abort  = abort_reg;

endmodule

// File: doc/lemming_dig_sched.md
Name: lemming_dig_sched

Overview:
- Shares one dig tool (the digger) among N_LEM lemming walkers using a round-robin policy.
- Each walker FSM raises dig_req while it wants to dig. The scheduler grants exactly one walker at a time and holds the grant for a fixed dig duration.
- A dig aborts early if the owner loses ground (starts falling).
- The block sits between the per-lemming walk/fall FSMs and the single digger datapath.

Parameters:
- N_LEM, 4, number of lemmings (requesters); must be >= 2.
- DIG_CYCLES, 8, cycles the grant is held for a completed dig; must be >= 1.
- IW, $clog2(N_LEM), width of the owner index.
- CW, $clog2(DIG_CYCLES)+1, width of the dig cycle counter.

Ports:
- clk, input, 1, rising-edge clock.
- areset, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
- dig_req, input, N_LEM, per-lemming dig request (level).
- ground, input, N_LEM, per-lemming "standing on ground" flag.
- dig_gnt, output, N_LEM, one-hot grant (all zero when idle); registered.
- dig_owner, output, IW, index of the current or last owner; registered.
- dig_active, output, 1, high while any grant is asserted.
- dig_done, output, 1, one-cycle pulse after a dig completes normally.
- dig_abort, output, 1, one-cycle pulse after a dig ends on ground loss.

Behaviour:
- Reset: state=IDLE, dig_gnt=0, dig_owner=0, dig_active=0, dig_done=0, dig_abort=0, cnt=0, rr_ptr=0 (lemming 0 has highest priority first). Reset mid-dig drops the grant on the same edge with no done/abort pulse.
- Eligibility: eligible = dig_req & ground. A requester that is not on ground is never granted.
- FSM states: IDLE, DIG, RELEASE.
- IDLE:
  - If eligible != 0, pick the first set bit at or after rr_ptr, searching cyclically upward with wrap from N_LEM-1 to 0.
  - On that edge: dig_gnt = one-hot(pick), dig_owner = pick, cnt = DIG_CYCLES-1, go to DIG.
  - Latency: a request sampled at edge k produces the grant visible after edge k.
- DIG:
  - dig_gnt and dig_owner are held stable; dig_req changes (including the owner dropping its request) are ignored.
  - Completion: cnt==0 -> next edge clears the grant, sets dig_done=1, goes to RELEASE.
  - Abort: ground[dig_owner]==0 with cnt!=0 -> next edge clears the grant, sets dig_abort=1, goes to RELEASE.
  - Otherwise: cnt decrements by 1.
  - A normal dig holds the grant for exactly DIG_CYCLES cycles.
  - Simultaneous cnt==0 and ground loss: completion wins (dig_done=1, dig_abort=0).
- RELEASE:
  - Lasts one cycle with no grant. dig_done/dig_abort are high only during this cycle.
  - rr_ptr = (dig_owner+1) mod N_LEM, updated on the transition out of DIG.
  - Next state is IDLE; requests are not evaluated in RELEASE.
  - Minimum gap between consecutive grants is 2 cycles (RELEASE + IDLE arbitration).
- dig_active == |dig_gnt at all times.
- dig_owner keeps its last value after release.
- rr_ptr wrap: N_LEM-1 -> 0. With N_LEM not a power of two, the pointer never exceeds N_LEM-1.
- Counter: unsigned, CW bits, never underflows (cnt is only decremented when cnt != 0).
- Assertions:
  - dig_gnt is one-hot or zero.
  - dig_done and dig_abort are never both high.
  - No grant is asserted in RELEASE.

Decomposition:
- Package lemming_pkg holds:
  - state enum {IDLE, DIG, RELEASE}.
  - Default constants N_LEM_DEF=4, DIG_CYCLES_DEF=8.
- One combinational sub-module lemming_rr_pick:
  - Inputs: eligible vector, rr_ptr.
  - Outputs: valid, pick index.
  - Implement with a double-width rotate or masked priority encode.
- The top level keeps the FSM, counter, pointer and output registers.

Test Plan:
1. Basic dig: areset 2 cycles, then dig_req=0010, ground=1111 -> dig_gnt=0010 after the next edge, held 8 cycles, dig_owner=1; then dig_done=1 for 1 cycle, dig_gnt=0000.
2. Round-robin fairness: dig_req=1111, ground=1111 held.
   - Grants come in order 0001, 0010, 0100, 1000, 0001.
   - Each grant lasts 8 cycles, followed by a 2-cycle gap with gnt=0.
   - dig_done pulses 4 times.
3. Abort on fall: owner 2 granted; drop ground[2] in the 3rd DIG cycle -> gnt=0000 after the next edge, dig_abort=1 for 1 cycle, dig_done=0; with dig_req=1100, the next grant is 1000.
4. Ineligible requester: dig_req=0100, ground=1011 -> no grant for 5 cycles; raise ground[2] -> dig_gnt=0100 after the next edge.
5. Simultaneous end: drop ground[owner] in the cycle where cnt==0 -> dig_done=1, dig_abort=0; the grant lasted exactly 8 cycles.
6. Reset mid-dig: assert areset in the 4th DIG cycle -> dig_gnt=0, dig_done=0, dig_abort=0 after that edge; with dig_req=1010 held after reset, the first grant is 0010 (rr_ptr back at 0).
